i2s_sample_fifo: RTL and testbench
==================================

// Module: i2s_sample_fifo
// PURPOSE
//  Sample buffer directly upstream of i2s_master. Accepts 16-bit signed mono samples from the
//  SID voice mixer at an arbitrary rate via valid/ready, and drives i2s_master.SMP exactly one
//  new sample per I2S frame. Paced by i2s_master's LCK output; both blocks share CLK.
//  Absorbs SID-vs-codec rate jitter. Underruns are flagged, never glitch SMP.
// PARAMETERS
//  DEPTH_LOG2   4    FIFO depth = 2**DEPTH_LOG2 entries (16).
//  WIDTH        16   sample width, two's complement; must equal i2s_master SMP width.
// PORTS
//  CLK        in   1             system clock (~24 MHz), same clock as i2s_master
//  RST        in   1             asynchronous reset, active-high
//  IN_DATA    in   WIDTH         sample from mixer
//  IN_VALID   in   1             IN_DATA valid
//  IN_READY   out  1             FIFO can accept; write occurs when IN_VALID & IN_READY
//  LCK        in   1             word clock from i2s_master (frame pacing)
//  SMP        out  WIDTH         sample to i2s_master.SMP, registered
//  LEVEL      out  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2
//  UNDERFLOW  out  1             1-cycle pulse: frame pop found FIFO empty
//  UNDERRUN_CNT out 16           present only with I2S_FIFO_STATS_EN
// BEHAVIOUR
//  Reset (async, RST=1): wr_ptr=rd_ptr=0, LEVEL=0, SMP=0, UNDERFLOW=0, lck_q=0, UNDERRUN_CNT=0.
//   IN_READY=1 (comb. ~full). RST mid-operation discards all contents; no partial writes survive.
//  Write: on CLK edge with IN_VALID & IN_READY, mem[wr_ptr]<=IN_DATA, wr_ptr++ (mod depth).
//   IN_READY = (LEVEL != 2**DEPTH_LOG2); combinational from registered LEVEL only.
//   Full + same-cycle pop: IN_READY still 0 that cycle (no write-through-on-full).
//  Pop event: lck_q <= LCK; pop = LCK & ~lck_q (LCK rising edge, right-channel half).
//   i2s_master latches SMP at LCK falling edge, so SMP changes only at rising edges,
//   giving >= half-frame setup. SMP is constant between pops.
//  Pop, LEVEL>0: SMP <= mem[rd_ptr], rd_ptr++; SMP valid the cycle after pop is detected
//   (2 CLK after LCK rises).
//  Pop, LEVEL==0: SMP holds previous value (no click), UNDERFLOW=1 for one cycle,
//   rd_ptr unchanged.
//  Simultaneous write + pop: LEVEL unchanged (+1-1); empty + write + pop -> underflow
//   reported, written sample kept (LEVEL becomes 1), next pop returns it.
//  LEVEL: +1 on write only, -1 on successful pop only; never wraps beyond 0..2**DEPTH_LOG2.
//  Pointers DEPTH_LOG2 bits wide, wrap naturally. Samples output in write order, no reorder.
//  No arithmetic on sample data; bit-exact passthrough.
// CONFIGURATION
//  I2S_FIFO_STATS_EN defined: UNDERRUN_CNT port exists; increments on each UNDERFLOW pulse,
//   saturates at 16'hFFFF, cleared only by RST.
//  Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Shared include i2s_defs.vh: `I2S_SMP_W (16), `I2S_SMP_ZERO (16'h0000), used by
//   i2s_master and this block.
//  Sub-module i2s_fifo_ram: 2**DEPTH_LOG2 x WIDTH register file, 1 sync write port,
//   1 async read port (SMP register sits in parent). Control/pointers/LEVEL in parent.
// TESTING
//  1 Reset: RST=1 with IN_VALID=1 -> SMP=0, LEVEL=0, IN_READY=1, no write; release, no spurious pop.
//  2 Order: write 16'h55AA,16'h1234,16'h8001, run i2s_master frames -> SMP sequence
//    55AA,1234,8001, each change only 2 CLK after LCK rise.
//  3 Full: hold IN_VALID=1, no LCK edges -> LEVEL=16, IN_READY=0; 17th sample not stored; one pop
//    -> IN_READY=1 next cycle.
//  4 Underflow: empty FIFO, LCK rises -> SMP holds last value, UNDERFLOW one pulse,
//    UNDERRUN_CNT=1 (STATS_EN).
//  5 Simultaneous: LEVEL=0, write 16'h7FFF on pop cycle -> UNDERFLOW pulses, LEVEL=1,
//    next pop SMP=7FFF.
//  6 Mid-op reset: RST pulse with LEVEL=5 -> LEVEL=0, SMP=0 immediately (async), pointers 0.

Source files
------------

// File: rtl/i2s_sample_fifo_pkg.sv
// Shared constants and helpers for the I2S sample FIFO.
// Sample width matches i2s_master SMP; saturating counter helper.
package i2s_sample_fifo_pkg;

   localparam int          SMP_W    = 16;
   localparam logic [15:0] SMP_ZERO = 16'h0000;
   localparam int          DEPTH_LOG2_DEF = 4;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/i2s_fifo_ram.sv
// 2**DEPTH_LOG2 x WIDTH register file, one sync write, one async read.
// Ports: clk, we, waddr, wdata, raddr, rdata.
module i2s_fifo_ram #(
   parameter int DEPTH_LOG2 = 4,
   parameter int WIDTH      = 16
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output logic [WIDTH-1:0]      rdata
);

   logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/i2s_sample_fifo.sv
// Sample FIFO feeding i2s_master; one pop per frame on LCK rise.
// Ports: CLK, RST, IN_DATA/IN_VALID/IN_READY, LCK, SMP, LEVEL,
// UNDERFLOW, UNDERRUN_CNT (only with I2S_FIFO_STATS_EN defined).
module i2s_sample_fifo
   import i2s_sample_fifo_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
   parameter int WIDTH      = SMP_W
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [WIDTH-1:0]      IN_DATA,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   input  logic                  LCK,
   output logic [WIDTH-1:0]      SMP,
   output logic [DEPTH_LOG2:0]   LEVEL,
   output logic                  UNDERFLOW
`ifdef I2S_FIFO_STATS_EN
   ,
   output logic [15:0]           UNDERRUN_CNT
`endif
);

   localparam logic [DEPTH_LOG2:0] FULL =
      {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0] LVL_ONE = 1;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  lck_q;
   logic                  pop_q;
   logic [WIDTH-1:0]      rd_data;
   logic                  wr_en;
   logic                  rd_ok;
   logic                  empty;

   assign IN_READY = (LEVEL != FULL);
   assign empty    = (LEVEL == '0);
   assign wr_en    = IN_VALID & IN_READY;
   assign rd_ok    = pop_q & ~empty;

   i2s_fifo_ram #(
      .DEPTH_LOG2(DEPTH_LOG2),
      .WIDTH     (WIDTH)
   ) u_ram (
      .clk  (CLK),
      .we   (wr_en),
      .waddr(wr_ptr),
      .wdata(IN_DATA),
      .raddr(rd_ptr),
      .rdata(rd_data)
   );

   // Edge is registered once more so SMP moves two clocks after
   // LCK rises, well clear of the falling-edge latch in i2s_master.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         lck_q     <= 1'b0;
         pop_q     <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         LEVEL     <= '0;
         SMP       <= WIDTH'(SMP_ZERO);
         UNDERFLOW <= 1'b0;
      end else begin
         lck_q     <= LCK;
         pop_q     <= LCK & ~lck_q;
         UNDERFLOW <= pop_q & empty;
         if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_ok) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            SMP    <= rd_data;
         end
         unique case ({wr_en, rd_ok})
            2'b10:   LEVEL <= LEVEL + LVL_ONE;
            2'b01:   LEVEL <= LEVEL - LVL_ONE;
            default: LEVEL <= LEVEL;
         endcase
      end
   end

`ifdef I2S_FIFO_STATS_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)            UNDERRUN_CNT <= '0;
      else if (UNDERFLOW) UNDERRUN_CNT <= sat_inc16(UNDERRUN_CNT);
   end
`endif

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Self-checking bench for i2s_sample_fifo.
// Table-driven frame sequence plus reset/full/mid-op-reset sequences.
module tb_i2s_sample_fifo;

   logic        clk;
   logic        rst;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        lck;
   logic [15:0] smp;
   logic [4:0]  level;
   logic        underflow;
`ifdef I2S_FIFO_STATS_EN
   logic [15:0] underrun_cnt;
`endif

   int total = 0;
   int bad   = 0;

   i2s_sample_fifo dut (
      .CLK      (clk),
      .RST      (rst),
      .IN_DATA  (in_data),
      .IN_VALID (in_valid),
      .IN_READY (in_ready),
      .LCK      (lck),
      .SMP      (smp),
      .LEVEL    (level),
      .UNDERFLOW(underflow)
`ifdef I2S_FIFO_STATS_EN
      ,
      .UNDERRUN_CNT(underrun_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [15:0] data;
      logic        lck;
      logic [15:0] smp;
      logic [4:0]  level;
      logic        ready;
      logic        uf;
   } vec_t;

   vec_t tv [23];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // LCK rise; returns right after the edge where SMP updates
   task automatic pop_rise();
      lck = 1'b1;
      step();
      step();
   endtask

   task automatic lck_low();
      lck = 1'b0;
      step();
   endtask

   function automatic vec_t mk(input logic v, input logic [15:0] d,
                               input logic l, input logic [15:0] s,
                               input logic [4:0] lv, input logic r,
                               input logic u);
      vec_t t;
      t.valid = v; t.data = d; t.lck = l; t.smp = s;
      t.level = lv; t.ready = r; t.uf = u;
      return t;
   endfunction

   initial begin
      // write three, then frames pop them in order, then underflow,
      // then empty + write + pop
      tv[0]  = mk(1, 16'h55AA, 0, 16'h0000, 1, 1, 0);
      tv[1]  = mk(1, 16'h1234, 0, 16'h0000, 2, 1, 0);
      tv[2]  = mk(1, 16'h8001, 0, 16'h0000, 3, 1, 0);
      tv[3]  = mk(0, 16'h0000, 1, 16'h0000, 3, 1, 0);
      tv[4]  = mk(0, 16'h0000, 1, 16'h55AA, 2, 1, 0);
      tv[5]  = mk(0, 16'h0000, 1, 16'h55AA, 2, 1, 0);
      tv[6]  = mk(0, 16'h0000, 0, 16'h55AA, 2, 1, 0);
      tv[7]  = mk(0, 16'h0000, 0, 16'h55AA, 2, 1, 0);
      tv[8]  = mk(0, 16'h0000, 1, 16'h55AA, 2, 1, 0);
      tv[9]  = mk(0, 16'h0000, 1, 16'h1234, 1, 1, 0);
      tv[10] = mk(0, 16'h0000, 0, 16'h1234, 1, 1, 0);
      tv[11] = mk(0, 16'h0000, 1, 16'h1234, 1, 1, 0);
      tv[12] = mk(0, 16'h0000, 1, 16'h8001, 0, 1, 0);
      tv[13] = mk(0, 16'h0000, 0, 16'h8001, 0, 1, 0);
      tv[14] = mk(0, 16'h0000, 1, 16'h8001, 0, 1, 0);
      tv[15] = mk(0, 16'h0000, 1, 16'h8001, 0, 1, 1);
      tv[16] = mk(0, 16'h0000, 1, 16'h8001, 0, 1, 0);
      tv[17] = mk(0, 16'h0000, 0, 16'h8001, 0, 1, 0);
      tv[18] = mk(0, 16'h0000, 1, 16'h8001, 0, 1, 0);
      tv[19] = mk(1, 16'h7FFF, 1, 16'h8001, 1, 1, 1);
      tv[20] = mk(0, 16'h0000, 0, 16'h8001, 1, 1, 0);
      tv[21] = mk(0, 16'h0000, 1, 16'h8001, 1, 1, 0);
      tv[22] = mk(0, 16'h0000, 1, 16'h7FFF, 0, 1, 0);

      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 16'hDEAD;
      lck = 1'b0;

      // reset held with valid asserted: nothing stored
      step(); step(); step();
      chk("rst_smp", 32'(smp), 32'h0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_uf", 32'(underflow), 32'd0);
      in_valid = 1'b0;
      rst = 1'b0;
      step();
      step();
      chk("rel_level", 32'(level), 32'd0);
      chk("rel_smp", 32'(smp), 32'h0);
      chk("rel_uf", 32'(underflow), 32'd0);

      for (int i = 0; i < 23; i++) begin
         in_valid = tv[i].valid;
         in_data  = tv[i].data;
         lck      = tv[i].lck;
         step();
         chk($sformatf("v%0d_smp", i), 32'(smp), 32'(tv[i].smp));
         chk($sformatf("v%0d_lvl", i), 32'(level), 32'(tv[i].level));
         chk($sformatf("v%0d_rdy", i), 32'(in_ready), 32'(tv[i].ready));
         chk($sformatf("v%0d_uf", i), 32'(underflow), 32'(tv[i].uf));
      end
      in_valid = 1'b0;
      lck_low();

      // fill past full with LCK idle
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_data  = 16'hA000 + 16'(i);
         step();
      end
      in_valid = 1'b0;
      chk("full_level", 32'(level), 32'd16);
      chk("full_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < 16; i++) begin
         pop_rise();
         chk($sformatf("drain%0d", i), 32'(smp), 32'(16'hA000 + 16'(i)));
         if (i == 0) begin
            chk("pop_ready", 32'(in_ready), 32'd1);
            chk("pop_level", 32'(level), 32'd15);
         end
         lck_low();
      end
      chk("drain_level", 32'(level), 32'd0);

      // empty pop: SMP holds, single pulse
      pop_rise();
      chk("uf_pulse", 32'(underflow), 32'd1);
      chk("uf_hold", 32'(smp), 32'hA00F);
      lck_low();
      chk("uf_once", 32'(underflow), 32'd0);
      chk("uf_level", 32'(level), 32'd0);
`ifdef I2S_FIFO_STATS_EN
      chk("cnt3", 32'(underrun_cnt), 32'd3);
`endif

      // mid-operation async reset
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data  = 16'hB000 + 16'(i);
         step();
      end
      in_valid = 1'b0;
      pop_rise();
      lck_low();
      chk("pre_smp", 32'(smp), 32'hB000);
      chk("pre_level", 32'(level), 32'd5);
      rst = 1'b1;
      #1;
      chk("arst_level", 32'(level), 32'd0);
      chk("arst_smp", 32'(smp), 32'h0);
      chk("arst_ready", 32'(in_ready), 32'd1);
`ifdef I2S_FIFO_STATS_EN
      chk("arst_cnt", 32'(underrun_cnt), 32'd0);
`endif
      step();
      rst = 1'b0;
      step();
      in_valid = 1'b1;
      in_data  = 16'hC000;
      step();
      in_valid = 1'b0;
      chk("post_level", 32'(level), 32'd1);
      pop_rise();
      chk("post_smp", 32'(smp), 32'hC000);
      chk("post_uf", 32'(underflow), 32'd0);
      lck_low();
      chk("post_empty", 32'(level), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
